// File: rtl/uart_io.sv
// uart_io: CPU I/O-port front end for a transmit-only 8N1 UART (port 8 = TX data, port 10 = status).
// Latency: start bit and busy appear on the clk edge that accepts a port-8 write; a frame is 10 bit periods.
// Backpressure: none; a port-8 write while busy is dropped. Optional UART_READBACK_EN makes port 8 readable.

module uart_io #(
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Address,
    inout  wire  [7:0] Data,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    output logic       uart_tx
);

    localparam logic [7:0] PORT_TX     = 8'd8;
    localparam logic [7:0] PORT_STATUS = 8'd10;

    logic       w_wr_qual;
    logic       w_wr_pulse;
    logic       w_accept;
    logic       w_busy;
    logic       w_rd_status;
    logic       w_rd_en;
    logic [7:0] w_rd_dat;
    logic       r_wr_q;

    // Port decodes; a write is only taken on the first cycle its qualified strobe is high.
    assign w_wr_qual   = IORQ & WR & (Address == PORT_TX);
    assign w_rd_status = IORQ & RD & (Address == PORT_STATUS);
    assign w_wr_pulse  = w_wr_qual & ~r_wr_q;
    assign w_accept    = w_wr_pulse & ~w_busy;

    // Remember last cycle's qualified strobe so a long strobe yields one frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_q <= 1'b0;
        end else begin
            r_wr_q <= w_wr_qual;
        end
    end

`ifdef UART_READBACK_EN
    logic       w_rd_tx;
    logic [7:0] r_readback;

    assign w_rd_tx = IORQ & RD & (Address == PORT_TX);

    // Hold the last byte actually handed to the transmitter (dropped writes do not count).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readback <= 8'h00;
        end else if (w_accept) begin
            r_readback <= Data;
        end
    end

    // Read mux: status port, plus the readback port.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_dat = 8'h00;
        if (w_rd_status) begin
            w_rd_en  = 1'b1;
            w_rd_dat = {7'b0, w_busy};
        end else if (w_rd_tx) begin
            w_rd_en  = 1'b1;
            w_rd_dat = r_readback;
        end
    end
`else
    // Read mux: only the status port is readable.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_dat = 8'h00;
        if (w_rd_status) begin
            w_rd_en  = 1'b1;
            w_rd_dat = {7'b0, w_busy};
        end
    end
`endif

    // Bus is released whenever no read decode is active; writes never drive it.
    assign Data = w_rd_en ? w_rd_dat : 8'bz;

    uart_io_tx #(
        .CLOCK (CLOCK),
        .BAUD  (BAUD)
    ) uart_core_ (
        .clk    (clk),
        .rst_n  (reset),
        .i_start(w_accept),
        .i_data (Data),
        .o_tx   (uart_tx),
        .o_busy (w_busy)
    );

endmodule

// uart_io_tx: 8N1 serial transmitter, one start bit, 8 data bits LSB first, one stop bit.
// Latency: line goes low on the edge that samples i_start in IDLE; busy drops on the edge ending the stop bit.
// Backpressure: i_start is ignored unless idle; caller must check o_busy.

module uart_io_tx #(
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy
);

    // Bit period derived here so an override of this instance's BAUD takes effect.
    localparam int CPB_RAW = CLOCK / BAUD;
    localparam int CPB     = (CPB_RAW < 1) ? 1 : CPB_RAW;
    localparam int CW      = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          w_bit_end;

    assign w_bit_end = (r_baud_cnt == LAST);
    assign o_tx      = r_tx;
    assign o_busy    = r_busy;

    // Frame sequencer; line and busy are registered so they change exactly on state edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                    if (i_start) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io at 2 clk cycles per bit; undriven Data bus reads FFh through pullups.
// Inputs change and outputs are sampled on the falling clock edge.
// Each comparison is an immediate assertion; the summary reports vectors and miscompares.

module tb_uart_io;

    logic       clk;
    logic       reset;
    logic [7:0] Address;
    logic       IORQ;
    logic       RD;
    logic       WR;
    logic       uart_tx;
    logic [7:0] r_drv;
    logic       r_drv_en;
    wire  [7:0] Data;

    int n_vec  = 0;
    int n_miss = 0;
    logic idle_ok;

    assign Data = r_drv_en ? r_drv : 8'bz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (Data[g]);
    end

    uart_io #(
        .CLOCK(50000000),
        .BAUD (25000000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Address(Address),
        .Data   (Data),
        .IORQ   (IORQ),
        .RD     (RD),
        .WR     (WR),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus;
        IORQ     = 1'b0;
        RD       = 1'b0;
        WR       = 1'b0;
        r_drv_en = 1'b0;
        Address  = 8'h00;
        #1;
    endtask

    task automatic read_port(input logic [7:0] a);
        r_drv_en = 1'b0;
        WR       = 1'b0;
        Address  = a;
        IORQ     = 1'b1;
        RD       = 1'b1;
        #1;
    endtask

    task automatic write_start(input logic [7:0] a, input logic [7:0] d);
        RD       = 1'b0;
        Address  = a;
        r_drv    = d;
        r_drv_en = 1'b1;
        IORQ     = 1'b1;
        WR       = 1'b1;
    endtask

    // Expected line level for frame bit k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        reset    = 1'b0;
        IORQ     = 1'b0;
        RD       = 1'b0;
        WR       = 1'b0;
        Address  = 8'h00;
        r_drv    = 8'h00;
        r_drv_en = 1'b0;

        // Reset state
        tick;
        tick;
        check("rst_tx", {7'b0, uart_tx}, 8'h01);
        read_port(8'd10);
        check("rst_status", Data, 8'h00);
        idle_bus;
        reset = 1'b1;
        tick;
        check("post_rst_tx", {7'b0, uart_tx}, 8'h01);
        read_port(8'd10);
        check("post_rst_status", Data, 8'h00);
        idle_bus;

        // High-Z cases
        check("no_decode_hiz", Data, 8'hFF);
        read_port(8'd9);
        check("port9_read_hiz", Data, 8'hFF);
        idle_bus;

        // Unused-port write does nothing
        write_start(8'd9, 8'h00);
        tick;
        idle_bus;
        idle_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (uart_tx !== 1'b1) idle_ok = 1'b0;
        end
        check("port9_write_no_frame", {7'b0, idle_ok}, 8'h01);
        read_port(8'd10);
        check("port9_write_status", Data, 8'h00);
        idle_bus;

        // 34h with 2-cycle strobe; status mid-frame and after
        write_start(8'd8, 8'h34);
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (i < 20) check($sformatf("f34_s%0d", i), {7'b0, uart_tx}, {7'b0, frame_bit(8'h34, i / 2)});
            else if (uart_tx !== 1'b1) idle_ok = 1'b0;
            if (i == 1) idle_bus;
            if (i == 7) begin
                read_port(8'd10);
                check("f34_busy", Data, 8'h01);
                idle_bus;
            end
            if (i == 37) begin
                read_port(8'd10);
                check("f34_done", Data, 8'h00);
                idle_bus;
            end
        end
        check("f34_single_frame", {7'b0, idle_ok}, 8'h01);

        // 55h, then AAh mid-frame is dropped
        write_start(8'd8, 8'h55);
        idle_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (i < 20) check($sformatf("f55_s%0d", i), {7'b0, uart_tx}, {7'b0, frame_bit(8'h55, i / 2)});
            else if (uart_tx !== 1'b1) idle_ok = 1'b0;
            if (i == 0) idle_bus;
            if (i == 9) write_start(8'd8, 8'hAA);
            if (i == 10) idle_bus;
        end
        check("fAA_dropped", {7'b0, idle_ok}, 8'h01);
        read_port(8'd8);
`ifdef UART_READBACK_EN
        check("readback_55", Data, 8'h55);
`else
        check("port8_read_hiz", Data, 8'hFF);
`endif
        idle_bus;

        // Reset during data bit 3 of a 00h frame
        write_start(8'd8, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick;
            if (i == 0) idle_bus;
        end
        check("bit3_low", {7'b0, uart_tx}, 8'h00);
        reset = 1'b0;
        #1;
        check("rst_mid_tx", {7'b0, uart_tx}, 8'h01);
        read_port(8'd10);
        check("rst_mid_busy", Data, 8'h00);
        idle_bus;
        tick;
        reset = 1'b1;
        tick;
        check("rst_mid_idle", {7'b0, uart_tx}, 8'h01);

        // A5h after the aborted frame
        write_start(8'd8, 8'hA5);
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (i < 20) check($sformatf("fA5_s%0d", i), {7'b0, uart_tx}, {7'b0, frame_bit(8'hA5, i / 2)});
            else if (uart_tx !== 1'b1) idle_ok = 1'b0;
            if (i == 0) idle_bus;
        end
        check("fA5_idle", {7'b0, idle_ok}, 8'h01);
        read_port(8'd10);
        check("fA5_status", Data, 8'h00);
        idle_bus;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_io.md
UART_IO -- requirements
Module: uart_io

Interface
REQ-001 Parameter CLOCK, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; forwarded to internal transmitter instance uart_core_ (hierarchical override uart_io.uart_core_.BAUD SHALL be honoured).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Address  input  8  I/O port address.
REQ-006 Data  inout  8  bidirectional CPU data bus.
REQ-007 IORQ  input  1  active-high I/O request.
REQ-008 RD  input  1  active-high read strobe.
REQ-009 WR  input  1  active-high write strobe.
REQ-010 uart_tx  output  1  serial transmit line, idle high.

Function
REQ-011 Port 8 (TX data) write: IORQ&WR&Address==8 SHALL load Data into the transmitter once per strobe, on the first clk edge where the qualified strobe is seen high after being low; a strobe held N cycles SHALL start exactly one frame.
REQ-012 A TX write while busy SHALL be ignored; byte dropped, frame in progress unaffected.
REQ-013 Port 10 (status) read: IORQ&RD&Address==10 SHALL drive Data = {7'b0, busy} combinationally.
REQ-014 Data SHALL be high-Z whenever no enabled read decode is active; writes never drive Data.
REQ-015 Bit period SHALL be CLOCK/BAUD clk cycles (integer division, minimum 1); CLOCK=50000000, BAUD=25000000 gives 2 cycles/bit.
REQ-016 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bit periods total, no parity.
REQ-017 Transmitter states: IDLE -> START -> DATA(bit 0..7) -> STOP -> IDLE; each state lasts one bit period, except DATA, which lasts eight.
REQ-018 busy SHALL rise on the clk edge that accepts the write and SHALL fall on the clk edge that ends the stop-bit period; uart_tx start bit SHALL begin on the same edge busy rises.
REQ-019 A new write accepted on the cycle busy falls or later SHALL start a new frame immediately (back-to-back frames allowed).
REQ-020 Unused addresses SHALL have no effect on reads or writes.

Reset
REQ-021 While reset is low: uart_tx=1, busy=0, state=IDLE, bit/baud counters=0, edge-detect register=0, readback register=0, Data high-Z.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; uart_tx returns high asynchronously.
REQ-023 After release, the first qualified write SHALL start a frame normally.

Configuration
REQ-024 Macro UART_READBACK_EN: when defined, IORQ&RD&Address==8 SHALL drive Data with the last byte accepted by a TX write (00h after reset); when undefined, port-8 reads SHALL leave Data high-Z and no readback register SHALL exist.

Verification (CLOCK=50000000, BAUD=25000000, 2 cycles/bit)
REQ-025 Reset low 2 cycles, then release -> uart_tx=1, port-10 read = 00h.
REQ-026 Write 34h to port 8 with strobe held 2 cycles -> uart_tx sequence 0,0,0,1,0,1,1,0,0,1 (each 2 cycles, 20 cycles total); exactly one frame.
REQ-027 Read port 10 6 cycles after strobe ends -> Data=01h; read again 30 cycles later -> Data=00h.
REQ-028 Write 55h, then write AAh at mid-frame -> only 55h transmitted, AAh dropped; with UART_READBACK_EN port-8 read returns 55h.
REQ-029 Reset pulsed low at data bit 3 of a frame -> uart_tx=1 immediately, busy=0; next write A5h transmits a complete frame.
REQ-030 No read decode active -> Data high-Z; read of port 9 -> Data high-Z.
